// File: rtl/ex_stage_nway.sv
// N-lane RV32I execute stage: per-lane operand forwarding, integer ALU and flag
// generation, captured in a registered EX/MEM slot with valid/ready, flush and perf counters.
module ex_stage_nway #(
  parameter int LANES      = 2,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_W      = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [LANES-1:0]            lane_en,
  input  logic [3*LANES-1:0]          f3,
  input  logic [7*LANES-1:0]          f7,
  input  logic [LANES-1:0]            use_imm,
  input  logic [DATA_WIDTH*LANES-1:0] imm,
  input  logic [DATA_WIDTH*LANES-1:0] rs1_val,
  input  logic [DATA_WIDTH*LANES-1:0] rs2_val,
  input  logic [4*LANES-1:0]          fwd_a,
  input  logic [4*LANES-1:0]          fwd_b,
  input  logic [DATA_WIDTH*LANES-1:0] exmem_res,
  input  logic [DATA_WIDTH*LANES-1:0] memwb_res,
  input  logic                        flush,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [LANES-1:0]            out_lane_en,
  output logic [DATA_WIDTH*LANES-1:0] out_result,
  output logic [DATA_WIDTH*LANES-1:0] out_store,
  output logic [4*LANES-1:0]          out_flags,
  output logic [CNT_W-1:0]            cnt_bundles,
  output logic [CNT_W-1:0]            cnt_stalls
);

  localparam int W  = DATA_WIDTH;
  localparam int SH = $clog2(DATA_WIDTH);

  // Only funct7[5] matters to the ALU.
  logic unused_f7;
  assign unused_f7 = ^f7;

  // Forwarding mux: rs, EX/MEM[j], MEM/WB[j], or an older lane j<k of this bundle.
  function automatic logic [W-1:0] fwd_pick(input logic [3:0] code, input int k,
                                            input logic [W-1:0] rs,
                                            input logic [W*LANES-1:0] own);
    int c;
    c = {28'd0, code};
    fwd_pick = rs;
    if (c >= 1 && c <= LANES)
      fwd_pick = exmem_res[W*(c-1) +: W];
    else if (c > LANES && c <= 2*LANES)
      fwd_pick = memwb_res[W*(c-1-LANES) +: W];
    else if (c > 2*LANES && (c - 1 - 2*LANES) < k)
      fwd_pick = own[W*(c-1-2*LANES) +: W];
  endfunction

  // Returns {Z, N, C, V, result}. SLT/SLTU reuse the subtractor so C and V come from it.
  function automatic logic [W+3:0] alu(input logic [2:0] op, input logic f7b5,
                                       input logic imm_sel,
                                       input logic [W-1:0] a, input logic [W-1:0] b);
    logic              sub;
    logic              arith;
    logic              ovf;
    logic              lt;
    logic [W-1:0]      bx;
    logic [W:0]        sum;
    logic [W-1:0]      r;
    logic signed [W-1:0] as;
    logic [SH-1:0]     sa;
    sub   = ((op == 3'b000) && f7b5 && !imm_sel) || (op == 3'b010) || (op == 3'b011);
    arith = (op == 3'b000) || (op == 3'b010) || (op == 3'b011);
    bx    = sub ? ~b : b;
    sum   = {1'b0, a} + {1'b0, bx} + {{W{1'b0}}, sub};
    ovf   = (a[W-1] == bx[W-1]) && (sum[W-1] != a[W-1]);
    lt    = sum[W-1] ^ ovf;
    sa    = b[SH-1:0];
    as    = a;
    r     = '0;
    case (op)
      3'b000: r = sum[W-1:0];
      3'b001: r = a << sa;
      3'b010: r = {{(W-1){1'b0}}, lt};
      3'b011: r = {{(W-1){1'b0}}, ~sum[W]};
      3'b100: r = a ^ b;
      3'b101: begin
        if (f7b5) r = as >>> sa;
        else      r = a >> sa;
      end
      3'b110: r = a | b;
      default: r = a & b;
    endcase
    alu = {(r == '0), r[W-1], arith & sum[W], arith & ovf, r};
  endfunction

  logic [W*LANES-1:0] raw;
  logic [W*LANES-1:0] res_c;
  logic [W*LANES-1:0] store_c;
  logic [4*LANES-1:0] flags_c;
  logic [W-1:0]       opa;
  logic [W-1:0]       opb;
  logic [W-1:0]       r_c;
  logic [3:0]         fl_c;

  // Stage p0: lanes evaluated in order so younger lanes see older combinational results.
  always_comb begin
    raw     = '0;
    res_c   = '0;
    store_c = '0;
    flags_c = '0;
    opa     = '0;
    opb     = '0;
    r_c     = '0;
    fl_c    = '0;
    for (int k = 0; k < LANES; k++) begin
      opa = fwd_pick(fwd_a[4*k +: 4], k, rs1_val[W*k +: W], raw);
      opb = fwd_pick(fwd_b[4*k +: 4], k, rs2_val[W*k +: W], raw);
      {fl_c, r_c} = alu(f3[3*k +: 3], f7[7*k+5], use_imm[k], opa,
                        use_imm[k] ? imm[W*k +: W] : opb);
      raw[W*k +: W] = r_c;
      if (lane_en[k]) begin
        res_c[W*k +: W]   = r_c;
        store_c[W*k +: W] = opb;
        flags_c[4*k +: 4] = fl_c;
      end
    end
  end

  logic load;
  logic stall;
  assign in_ready = !out_valid || out_ready;
  assign load     = in_valid && in_ready && !flush;
  assign stall    = in_valid && !in_ready;

  // Stage p1: registered EX/MEM slot and counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_lane_en <= '0;
      out_result  <= '0;
      out_store   <= '0;
      out_flags   <= '0;
      cnt_bundles <= '0;
      cnt_stalls  <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else begin
      if (load) begin
        out_valid   <= 1'b1;
        out_lane_en <= lane_en;
        out_result  <= res_c;
        out_store   <= store_c;
        out_flags   <= flags_c;
        cnt_bundles <= cnt_bundles + CNT_W'(1);
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (stall) cnt_stalls <= cnt_stalls + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_ex_stage_nway.sv
// Directed bench for ex_stage_nway (3 lanes): bench-side handshake model with an
// expected-bundle queue pushed at drive time and compared when the slot is valid.
module tb_ex_stage_nway;
  localparam int L = 3;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [L-1:0]   lane_en;
  logic [3*L-1:0] f3;
  logic [7*L-1:0] f7;
  logic [L-1:0]   use_imm;
  logic [W*L-1:0] imm, rs1_val, rs2_val, exmem_res, memwb_res;
  logic [4*L-1:0] fwd_a, fwd_b;
  logic           flush;
  logic           out_valid;
  logic           out_ready;
  logic [L-1:0]   out_lane_en;
  logic [W*L-1:0] out_result, out_store;
  logic [4*L-1:0] out_flags;
  logic [31:0]    cnt_bundles, cnt_stalls;

  ex_stage_nway #(.LANES(L), .DATA_WIDTH(W), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .lane_en(lane_en), .f3(f3), .f7(f7), .use_imm(use_imm), .imm(imm),
    .rs1_val(rs1_val), .rs2_val(rs2_val), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .exmem_res(exmem_res), .memwb_res(memwb_res), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_lane_en(out_lane_en),
    .out_result(out_result), .out_store(out_store), .out_flags(out_flags),
    .cnt_bundles(cnt_bundles), .cnt_stalls(cnt_stalls)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [L-1:0]   en;
    logic [W*L-1:0] res;
    logic [W*L-1:0] st;
    logic [4*L-1:0] fl;
  } exp_t;

  exp_t        sb[$];
  exp_t        nxt;
  logic        mv;
  logic        rst_seen;
  logic [31:0] cb, cs;
  int          total  = 0;
  int          passed = 0;
  int          fails  = 0;

  task automatic chk(input string tag, input logic [W*L-1:0] obs, input logic [W*L-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("out_valid", {95'd0, out_valid}, {95'd0, mv});
    chk("in_ready", {95'd0, in_ready}, {95'd0, (!mv || out_ready)});
    chk("cnt_bundles", {64'd0, cnt_bundles}, {64'd0, cb});
    chk("cnt_stalls", {64'd0, cnt_stalls}, {64'd0, cs});
    if (rst_seen) begin
      chk("rst_result", out_result, '0);
      chk("rst_store", out_store, '0);
      chk("rst_flags", {84'd0, out_flags}, '0);
      chk("rst_lane_en", {93'd0, out_lane_en}, '0);
    end
    if (mv && sb.size() > 0) begin
      chk("lane_en", {93'd0, out_lane_en}, {93'd0, sb[0].en});
      chk("result", out_result, sb[0].res);
      chk("store", out_store, sb[0].st);
      chk("flags", {84'd0, out_flags}, {84'd0, sb[0].fl});
    end
  endtask

  // Advance one clock, updating the expected slot model from the driven inputs first.
  task automatic tick();
    logic rdy;
    logic ld;
    rdy = !mv || out_ready;
    rst_seen = rst;
    if (rst) begin
      mv = 1'b0; sb.delete(); cb = '0; cs = '0;
    end else if (flush) begin
      mv = 1'b0; sb.delete();
    end else begin
      ld = in_valid && rdy;
      if (in_valid && !rdy) cs = cs + 1;
      if (mv && out_ready && sb.size() > 0) void'(sb.pop_front());
      if (ld) begin sb.push_back(nxt); cb = cb + 1; end
      mv = ld || (mv && !out_ready);
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic clear();
    in_valid = 0; lane_en = '0; f3 = '0; f7 = '0; use_imm = '0; imm = '0;
    rs1_val = '0; rs2_val = '0; fwd_a = '0; fwd_b = '0; exmem_res = '0;
    memwb_res = '0; flush = 0; nxt = '0;
  endtask

  task automatic lane(input int k, input logic [2:0] op, input logic [6:0] f7v,
                      input logic ui, input logic [31:0] immv, input logic [31:0] r1,
                      input logic [31:0] r2, input logic [3:0] fa, input logic [3:0] fb);
    lane_en[k] = 1'b1; f3[3*k +: 3] = op; f7[7*k +: 7] = f7v; use_imm[k] = ui;
    imm[W*k +: W] = immv; rs1_val[W*k +: W] = r1; rs2_val[W*k +: W] = r2;
    fwd_a[4*k +: 4] = fa; fwd_b[4*k +: 4] = fb;
  endtask

  task automatic expl(input int k, input logic [31:0] r, input logic [31:0] s, input logic [3:0] f);
    nxt.en[k] = 1'b1; nxt.res[W*k +: W] = r; nxt.st[W*k +: W] = s; nxt.fl[4*k +: 4] = f;
  endtask

  initial begin
    mv = 0; cb = 0; cs = 0; rst_seen = 0;
    clear(); rst = 1; out_ready = 1;
    tick(); tick();
    rst = 0;
    tick();

    // Single lane ADD 5+7
    clear(); lane(0, 3'b000, 7'h00, 0, 0, 5, 7, 0, 0); expl(0, 12, 7, 4'b0000);
    in_valid = 1; tick();
    clear(); tick();

    // Intra-bundle chain; lane0 uses illegal code 9; lane1 has f7[5] with imm (still ADD)
    clear();
    lane(0, 3'b000, 7'h20, 0, 0, 3, 5, 4'd9, 0);            expl(0, 32'hFFFF_FFFE, 5, 4'b0100);
    lane(1, 3'b000, 7'h20, 1, 1, 32'h1234, 32'h55, 4'd7, 0); expl(1, 32'hFFFF_FFFF, 32'h55, 4'b0100);
    lane(2, 3'b000, 7'h00, 0, 0, 32'h9, 0, 4'd8, 0);         expl(2, 32'hFFFF_FFFF, 0, 4'b0100);
    in_valid = 1; tick();

    // EX/MEM and MEM/WB selection, back-to-back with previous bundle
    clear();
    exmem_res = {32'h0, 32'h10, 32'hDEAD};
    memwb_res = {32'h0, 32'h8000_0000, 32'hBEEF};
    lane(0, 3'b000, 7'h00, 0, 0, 1, 32'h77, 0, 4'd2);            expl(0, 32'h11, 32'h10, 4'b0000);
    lane(1, 3'b000, 7'h00, 0, 0, 1, 32'h8000_0000, 4'd5, 0);     expl(1, 0, 32'h8000_0000, 4'b1011);
    in_valid = 1; tick();

    // SLT, SLTU, SRAI
    clear();
    lane(0, 3'b010, 7'h00, 0, 0, 32'hFFFF_FFFF, 1, 0, 0);        expl(0, 1, 1, 4'b0010);
    lane(1, 3'b011, 7'h00, 0, 0, 32'hFFFF_FFFF, 1, 0, 0);        expl(1, 0, 1, 4'b1010);
    lane(2, 3'b101, 7'h20, 1, 32'h404, 32'h8000_0000, 3, 0, 0);  expl(2, 32'hF800_0000, 3, 4'b0100);
    in_valid = 1; tick();

    // XOR, SLL (shamt from B[4:0]), AND
    clear();
    lane(0, 3'b100, 7'h00, 0, 0, 32'hA5A5, 32'hFFFF, 0, 0); expl(0, 32'h5A5A, 32'hFFFF, 4'b0000);
    lane(1, 3'b001, 7'h00, 0, 0, 1, 32'h21, 0, 0);          expl(1, 2, 32'h21, 4'b0000);
    lane(2, 3'b111, 7'h00, 0, 0, 32'hF0F0, 32'h0FF0, 0, 0); expl(2, 32'h00F0, 32'h0FF0, 4'b0000);
    in_valid = 1; tick();

    // Backpressure: load A, then hold out_ready low for three cycles with B offered
    clear(); lane(0, 3'b000, 7'h00, 0, 0, 1, 2, 0, 0); expl(0, 3, 2, 4'b0000);
    in_valid = 1; tick();
    clear(); lane(0, 3'b000, 7'h00, 0, 0, 100, 1, 0, 0); expl(0, 101, 1, 4'b0000);
    in_valid = 1; out_ready = 0;
    tick(); tick(); tick();
    chk("stalls_after_3", {64'd0, cnt_stalls}, 96'd3);
    out_ready = 1; tick();
    for (int i = 1; i <= 4; i++) begin
      clear(); lane(0, 3'b000, 7'h00, 0, 0, i * 10, i, 0, 0); expl(0, i * 11, i, 4'b0000);
      in_valid = 1; tick();
    end

    // Flush while holding a bundle and offering another
    clear(); lane(0, 3'b000, 7'h00, 0, 0, 9, 9, 0, 0); expl(0, 18, 9, 4'b0000);
    in_valid = 1; out_ready = 0; flush = 1; tick();
    clear(); out_ready = 1; tick();

    // Synchronous reset during a stall
    clear(); lane(0, 3'b000, 7'h00, 0, 0, 4, 4, 0, 0); expl(0, 8, 4, 4'b0000);
    in_valid = 1; tick();
    out_ready = 0; tick();
    rst = 1; tick();
    rst = 0; clear(); out_ready = 1; tick();

    // Disabled lane 1 registers zeros
    clear();
    lane(0, 3'b000, 7'h00, 0, 0, 5, 6, 0, 0); expl(0, 11, 6, 4'b0000);
    lane(1, 3'b000, 7'h00, 0, 0, 7, 8, 0, 0);
    lane_en = 3'b001;
    in_valid = 1; tick();
    clear(); tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
